// File: rtl/inst_fetch_mem_pkg.sv
// Shared definitions for the instruction fetch memory: NOP word, FSM encoding,
// and the index-width helper used to size word addresses.
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } imem_state_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_fetch_mem_if.sv
// Fetch/load bus of the instruction fetch memory; master drives requests,
// slave (the memory) returns the registered fetch result.
interface inst_fetch_mem_if #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) ();
  import imem_pkg::*;

  localparam int IDX_W = idx_w(DEPTH);

  logic              fetch_en;
  logic [31:0]       pc;
  logic              stall;
  logic              flush;
  logic              ld_we;
  logic [IDX_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              fault;
  logic              ready;

  modport master (
    output fetch_en, pc, stall, flush, ld_we, ld_addr, ld_data,
    input  instruction, inst_valid, fault, ready
  );

  modport slave (
    input  fetch_en, pc, stall, flush, ld_we, ld_addr, ld_data,
    output instruction, inst_valid, fault, ready
  );

endinterface

// File: rtl/inst_fetch_mem_ram.sv
// DEPTH x DATA_W instruction storage: one synchronous read port, one write
// port, read-first on a same-address collision. No reset on the array.
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Write and read in the same block; the read samples the pre-edge word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: clears itself after reset, then serves
// single-cycle-latency fetches with stall/flush and a program-load port.
module inst_fetch_mem #(
  parameter int          DEPTH     = 256,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  inst_fetch_mem_if.slave  bus
);
  import imem_pkg::*;

  localparam int               IDX_W     = idx_w(DEPTH);
  localparam logic [32:0]      BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0]      LIMIT_EXT = BASE_EXT + 33'(DEPTH * 4);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  imem_state_t       state_r;
  logic [IDX_W-1:0]  counter_r;
  logic              ready_r;
  logic              inst_valid_r;
  logic              fault_r;

  logic [32:0]       pc_ext_s;
  logic [32:0]       offset_s;
  logic              fault_s;
  logic              accept_s;
  logic [IDX_W-1:0]  idx_s;
  logic              ram_we_s;
  logic [IDX_W-1:0]  ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_q_s;

  // Address decode: 33-bit range compare so pc near 2^32 cannot wrap into range.
  always_comb begin
    pc_ext_s = {1'b0, bus.pc};
    offset_s = pc_ext_s - BASE_EXT;
    fault_s  = (bus.pc[1:0] != 2'b00) || (pc_ext_s < BASE_EXT) || (pc_ext_s >= LIMIT_EXT);
    idx_s    = IDX_W'(offset_s >> 2);
    accept_s = (state_r == S_READY) && bus.fetch_en && !bus.stall && !bus.flush;
  end

  // Write port mux: the clear sweep owns the port until initialisation ends.
  always_comb begin
    if (state_r == S_INIT) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = counter_r;
      ram_wdata_s = DATA_W'(NOP_WORD);
    end else begin
      ram_we_s    = bus.ld_we;
      ram_waddr_s = bus.ld_addr;
      ram_wdata_s = bus.ld_data;
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (accept_s),
    .rd_addr (idx_s),
    .rd_data (ram_q_s),
    .we      (ram_we_s),
    .wr_addr (ram_waddr_s),
    .wr_data (ram_wdata_s)
  );

  // Control FSM: clear sweep, then fetch result flags with flush > stall > fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_INIT;
      counter_r    <= {IDX_W{1'b0}};
      ready_r      <= 1'b0;
      inst_valid_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      case (state_r)
        S_INIT: begin
          inst_valid_r <= 1'b0;
          fault_r      <= 1'b0;
          if (counter_r == LAST_IDX) begin
            state_r   <= S_READY;
            ready_r   <= 1'b1;
            counter_r <= {IDX_W{1'b0}};
          end else begin
            counter_r <= counter_r + IDX_W'(1);
          end
        end
        S_READY: begin
          if (bus.flush) begin
            inst_valid_r <= 1'b0;
            fault_r      <= 1'b0;
          end else if (bus.stall) begin
            inst_valid_r <= inst_valid_r;
            fault_r      <= fault_r;
          end else if (bus.fetch_en) begin
            inst_valid_r <= !fault_s;
            fault_r      <= fault_s;
          end else begin
            inst_valid_r <= 1'b0;
            fault_r      <= 1'b0;
          end
        end
        default: begin
          state_r      <= S_INIT;
          counter_r    <= {IDX_W{1'b0}};
          ready_r      <= 1'b0;
          inst_valid_r <= 1'b0;
          fault_r      <= 1'b0;
        end
      endcase
    end
  end

  // The RAM output register only updates on accepted fetches, so it holds
  // through stalls; the valid flag masks it to zero otherwise.
  assign bus.instruction = inst_valid_r ? ram_q_s : {DATA_W{1'b0}};
  assign bus.inst_valid  = inst_valid_r;
  assign bus.fault       = fault_r;
  assign bus.ready       = ready_r;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem: vector table for cycle-by-cycle fetch
// behaviour plus hand-written reset/clear sequences.
module tb_inst_fetch_mem;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  inst_fetch_mem_if #(.DEPTH(256), .DATA_W(32)) bus ();

  inst_fetch_mem #(
    .DEPTH     (256),
    .DATA_W    (32),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        fetch_en;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_fault;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic fe, input logic [31:0] pc,
                              input logic st, input logic fl, input logic we,
                              input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] ei, input logic ev, input logic ef);
    vec_t v;
    v.name = name; v.fetch_en = fe; v.pc = pc; v.stall = st; v.flush = fl;
    v.ld_we = we; v.ld_addr = a; v.ld_data = d;
    v.exp_instr = ei; v.exp_valid = ev; v.exp_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fe, input logic [31:0] pc, input logic st, input logic fl,
                       input logic we, input logic [7:0] a, input logic [31:0] d);
    bus.fetch_en = fe; bus.pc = pc; bus.stall = st; bus.flush = fl;
    bus.ld_we = we; bus.ld_addr = a; bus.ld_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises; inst_valid must never assert meanwhile.
  task automatic wait_ready(input string name);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (!bus.ready && n < 600) begin
      step();
      n++;
      if (bus.inst_valid) bad++;
    end
    chk({name, "_cycles"}, 32'(n), 32'd256);
    chk({name, "_valid"}, 32'(bad), 32'd0);
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    #12;
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_instr", bus.instruction, 32'h0);

    // Fetches and loads during the clear sweep must be ignored.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 8'h07, 32'h5555_AAAA);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("init1");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    vq.push_back(mk("ld_w0",      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'd0, 32'h1000_0002, 32'h0,         1'b0, 1'b0));
    vq.push_back(mk("ld_w1",      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'd1, 32'h00A1_1824, 32'h0,         1'b0, 1'b0));
    vq.push_back(mk("fetch_0",    1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h1000_0002, 1'b1, 1'b0));
    vq.push_back(mk("fetch_4",    1'b1, 32'h4,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("misalign",   1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b1));
    vq.push_back(mk("past_end",   1'b1, 32'h400,      1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b1));
    vq.push_back(mk("last_word",  1'b1, 32'h3FC,      1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b1, 1'b0));
    vq.push_back(mk("no_wrap",    1'b1, 32'hFFFF_FFFC,1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b1));
    vq.push_back(mk("fetch_4b",   1'b1, 32'h4,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("stall_1",    1'b1, 32'h8,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0,         32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("stall_2",    1'b1, 32'h8,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0,         32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("stall_3",    1'b1, 32'h8,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0,         32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("stall_flush",1'b1, 32'h8,        1'b1, 1'b1, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b0));
    vq.push_back(mk("fault_pc1",  1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b1));
    vq.push_back(mk("stall_fault",1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b1));
    vq.push_back(mk("idle",       1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b0));
    vq.push_back(mk("rd_first",   1'b1, 32'h8,        1'b0, 1'b0, 1'b1, 8'd2, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0));
    vq.push_back(mk("refetch_8",  1'b1, 32'h8,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0));
    vq.push_back(mk("flush_fe",   1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 8'd0, 32'h0,         32'h0,         1'b0, 1'b0));
    vq.push_back(mk("fetch_4c",   1'b1, 32'h4,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("ld_in_stall",1'b1, 32'hC,        1'b1, 1'b0, 1'b1, 8'd3, 32'h1234_5678, 32'h00A1_1824, 1'b1, 1'b0));
    vq.push_back(mk("fetch_c",    1'b1, 32'hC,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'h1234_5678, 1'b1, 1'b0));
    vq.push_back(mk("ld_w5",      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'd5, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0));
    vq.push_back(mk("fetch_20",   1'b1, 32'd20,       1'b0, 1'b0, 1'b0, 8'd0, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].fetch_en, vq[i].pc, vq[i].stall, vq[i].flush,
            vq[i].ld_we, vq[i].ld_addr, vq[i].ld_data);
      step();
      chk({vq[i].name, "_instr"}, bus.instruction, vq[i].exp_instr);
      chk({vq[i].name, "_valid"}, {31'd0, bus.inst_valid}, {31'd0, vq[i].exp_valid});
      chk({vq[i].name, "_fault"}, {31'd0, bus.fault}, {31'd0, vq[i].exp_fault});
    end

    // Word 7 was targeted by a load during the first sweep; it must read as NOP.
    drive(1'b1, 32'd28, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("init_ld_ignored", bus.instruction, 32'h0);

    // Asynchronous reset mid-operation: outputs drop without a clock edge.
    drive(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("pre_rst_instr", bus.instruction, 32'hCAFE_F00D);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("async_rst_instr", bus.instruction, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'd20, 1'b0, 1'b0, 1'b1, 8'd5, 32'hFFFF_FFFF);
    wait_ready("init2");
    drive(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("clr_w5_instr", bus.instruction, 32'h0);
    chk("clr_w5_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("clr_w5_fault", {31'd0, bus.fault}, 32'd0);

    // Reset part-way through the sweep restarts the full clear.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd9, 32'hAAAA_5555);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("mid_init_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready("init3");
    drive(1'b1, 32'd36, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("clr_w9_instr", bus.instruction, 32'h0);
    chk("clr_w9_valid", {31'd0, bus.inst_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 Parameter DEPTH, default 256: number of instruction words; power of two, 16..4096.
REQ-002 Parameter DATA_W, default 32: instruction width in bits.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fetch_en  input  1  fetch request for pc this cycle.
REQ-007 pc  input  32  byte address of instruction to fetch.
REQ-008 stall  input  1  hold fetch output registers.
REQ-009 flush  input  1  replace next fetch output with NOP.
REQ-010 ld_we  input  1  program-load write strobe.
REQ-011 ld_addr  input  log2(DEPTH)  word index for load write.
REQ-012 ld_data  input  DATA_W  word to write.
REQ-013 instruction  output  DATA_W  registered fetched word.
REQ-014 inst_valid  output  1  instruction holds a real fetch result.
REQ-015 fault  output  1  registered: last accepted fetch misaligned or out of range.
REQ-016 ready  output  1  initialisation complete; fetch and load accepted.

Function
REQ-017 Two states: S_INIT, S_READY; reset enters S_INIT with clear counter = 0.
REQ-018 S_INIT writes NOP (all zeros) to word[counter] each cycle, counter +1; after writing word DEPTH-1, next state S_READY; S_INIT lasts exactly DEPTH cycles.
REQ-019 ready = 1 only in S_READY; in S_INIT fetch_en and ld_we are ignored, instruction = 0, inst_valid = 0, fault = 0.
REQ-020 Accepted fetch: S_READY & fetch_en & !stall & !flush; result appears on instruction/inst_valid/fault one cycle later (latency 1).
REQ-021 Word index = (pc - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits only after range check.
REQ-022 Fault when pc[1:0] != 0, pc < BASE_ADDR, or pc >= BASE_ADDR + DEPTH*4 (unsigned, 33-bit compare, no wrap); on fault: instruction = 0, inst_valid = 0, fault = 1.
REQ-023 Valid accepted fetch: instruction = word[index], inst_valid = 1, fault = 0.
REQ-024 S_READY & fetch_en = 0 & !stall & !flush: next cycle instruction = 0, inst_valid = 0, fault = 0.
REQ-025 stall = 1 (flush = 0): instruction, inst_valid, fault hold their values.
REQ-026 flush = 1: next cycle instruction = 0, inst_valid = 0, fault = 0; flush has priority over stall and fetch_en.
REQ-027 S_READY & ld_we: word[ld_addr] <= ld_data at the clock edge; loads are independent of stall/flush.
REQ-028 Load and fetch to the same word in the same cycle: fetch returns the old word (read-first); the new word is visible to fetches from the following cycle.
REQ-029 Memory contents persist across cycles until overwritten by a load or cleared by S_INIT.

Reset
REQ-030 reset asserted asynchronously forces instruction = 0, inst_valid = 0, fault = 0, ready = 0, state = S_INIT, counter = 0.
REQ-031 reset mid-S_INIT or mid-operation restarts the full DEPTH-cycle clear; previously loaded contents are lost.
REQ-032 Memory array itself has no reset; only the S_INIT sweep clears it.

Structure
REQ-033 Shared package imem_pkg holds the NOP constant (all zeros), the state encoding (S_INIT, S_READY), and DEPTH-derived index-width helper.
REQ-034 Storage is one sub-module imem_ram: DEPTH x DATA_W, one synchronous read port, one write port, read-first behaviour.
REQ-035 Write port mux: S_INIT clear (counter, NOP) else load port (ld_addr, ld_data).

Verification
REQ-036 Reset, DEPTH=256 -> ready = 0 for 256 cycles, ready = 1 on cycle 257; fetch of any pc in S_INIT -> inst_valid = 0.
REQ-037 Load word 0 = 32'h1000_0002, word 1 = 32'h00A1_1824; fetch pc=0 then pc=4 -> instruction 32'h1000_0002 then 32'h00A1_1824 one cycle after each, inst_valid = 1.
REQ-038 Fetch pc=32'h2 and pc=32'h400 (DEPTH=256, BASE=0) -> fault = 1, instruction = 0, inst_valid = 0; pc=32'h3FC -> fault = 0.
REQ-039 Fetch pc=4, then stall 3 cycles with pc=8 -> instruction holds word 1 for 3 cycles; stall + flush same cycle -> next cycle instruction = 0, inst_valid = 0.
REQ-040 Same cycle ld_we to word 2 (32'hDEAD_BEEF, old 0) and fetch pc=8 -> instruction = 0; refetch pc=8 -> 32'hDEAD_BEEF.
REQ-041 Load word 5, assert reset mid-run for 1 cycle -> 256-cycle clear repeats; fetch pc=20 after ready -> instruction = 0, inst_valid = 1.
